// File: rtl/sp_ram_bist_pkg.sv
// Shared types for the single-port RAM March C- BIST: FSM states, march
// element table and the mismatch counter width.
package sp_ram_bist_pkg;

    localparam int ERR_CNT_WIDTH = 16;
    localparam int NUM_ELEMS     = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // opN_inv selects the background: 0 -> PATTERN, 1 -> ~PATTERN.
    typedef struct packed {
        logic       descending;
        logic [1:0] op_cnt;
        logic       op0_wr;
        logic       op0_inv;
        logic       op1_wr;
        logic       op1_inv;
    } march_elem_t;

    localparam march_elem_t [0:NUM_ELEMS-1] MARCH_TABLE = '{
        '{descending: 1'b0, op_cnt: 2'd1, op0_wr: 1'b1, op0_inv: 1'b0, op1_wr: 1'b0, op1_inv: 1'b0},
        '{descending: 1'b0, op_cnt: 2'd2, op0_wr: 1'b0, op0_inv: 1'b0, op1_wr: 1'b1, op1_inv: 1'b1},
        '{descending: 1'b0, op_cnt: 2'd2, op0_wr: 1'b0, op0_inv: 1'b1, op1_wr: 1'b1, op1_inv: 1'b0},
        '{descending: 1'b1, op_cnt: 2'd2, op0_wr: 1'b0, op0_inv: 1'b0, op1_wr: 1'b1, op1_inv: 1'b1},
        '{descending: 1'b1, op_cnt: 2'd2, op0_wr: 1'b0, op0_inv: 1'b1, op1_wr: 1'b1, op1_inv: 1'b0},
        '{descending: 1'b0, op_cnt: 2'd1, op0_wr: 1'b0, op0_inv: 1'b0, op1_wr: 1'b0, op1_inv: 1'b0}
    };

endpackage

// File: rtl/sp_ram_bist_if.sv
// RAM request channel plus the expected read data that travels with each read.
interface sp_ram_bist_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);

    logic                    en;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   exp_data;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (output en, we, addr, wdata, be, exp_data, input rdata);
    modport slave  (input en, we, addr, wdata, be, output rdata);
    modport mon    (input en, we, addr, exp_data, rdata);

endinterface

// File: rtl/sp_ram_bist_chk.sv
// Read-data checker: registers the expected word at issue time, compares one
// cycle later, counts mismatches (saturating) and captures the first failure.
module sp_ram_bist_chk
    import sp_ram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_i,
    input  logic                     clr_i,
    sp_ram_bist_if.mon               bus,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
    output logic [ADDR_WIDTH-1:0]    fail_addr_o,
    output logic [DATA_WIDTH-1:0]    fail_data_o
);

    logic                     pend_q, pend_d;
    logic [DATA_WIDTH-1:0]    exp_q, exp_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]    fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0]    fail_data_q, fail_data_d;
    logic                     mismatch;

    assign mismatch = pend_q && (bus.rdata != exp_q);

    always_comb begin
        // NOTE: every _d gets a default before any branch, so no path holds a value and no latch is inferred.
        pend_d      = bus.en && !bus.we;
        exp_d       = exp_q;
        addr_d      = addr_q;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;

        if (pend_d) begin
            exp_d  = bus.exp_data;
            addr_d = bus.addr;
        end

        if (clr_i) begin
            pend_d      = 1'b0;
            err_cnt_d   = '0;
            fail_addr_d = '0;
            fail_data_d = '0;
        end else if (mismatch) begin
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            // A zero count means this is the first mismatch since the last clear.
            if (err_cnt_q == '0) begin
                fail_addr_d = addr_q;
                fail_data_d = bus.rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is simply the first branch inside the clocked block.
        if (rst_i) begin
            pend_q      <= 1'b0;
            exp_q       <= '0;
            addr_q      <= '0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            // NOTE: non-blocking updates, so every flop samples pre-edge values regardless of statement order.
            pend_q      <= pend_d;
            exp_q       <= exp_d;
            addr_q      <= addr_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign err_cnt_o   = err_cnt_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_data_o = fail_data_q;

endmodule

// File: rtl/sp_ram_bist.sv
// March C- BIST controller for a single-port RAM with 1-cycle read latency:
// FSM, element sequencing and address generation; checking lives in _chk.
module sp_ram_bist
    import sp_ram_bist_pkg::*;
#(
    parameter int                    RAM_SIZE   = 32768,
    parameter int                    ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 32'h5555_5555
) (
    input  logic                      clk,
    input  logic                      rst_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      pass_o,
    output logic [ERR_CNT_WIDTH-1:0]  err_cnt_o,
    output logic [ADDR_WIDTH-1:0]     fail_addr_o,
    output logic [DATA_WIDTH-1:0]     fail_data_o,
    output logic                      ram_en_o,
    output logic                      ram_we_o,
    output logic [ADDR_WIDTH-1:0]     ram_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   ram_be_o,
    input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

    localparam int BE_W       = DATA_WIDTH / 8;
    localparam int NUM_WORDS  = RAM_SIZE / BE_W;
    localparam int BYTE_SHIFT = $clog2(BE_W);
    localparam int WORD_AW    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [WORD_AW-1:0] LAST_WORD = WORD_AW'(NUM_WORDS - 1);
    localparam logic [2:0]         LAST_ELEM = 3'(NUM_ELEMS - 1);

    state_e             state_q, state_d;
    logic [2:0]         elem_q, elem_d;
    logic               op_q, op_d;
    logic [WORD_AW-1:0] word_q, word_d;

    march_elem_t cur;
    logic        run;
    logic        start_accept;
    logic        cur_wr;
    logic        cur_inv;
    logic        last_op;
    logic        last_word;

    logic [ERR_CNT_WIDTH-1:0] err_cnt;

    sp_ram_bist_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bus ();

    assign cur          = MARCH_TABLE[elem_q];
    assign run          = (state_q == RUN);
    assign start_accept = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign cur_wr       = op_q ? cur.op1_wr  : cur.op0_wr;
    assign cur_inv      = op_q ? cur.op1_inv : cur.op0_inv;
    assign last_op      = (cur.op_cnt == 2'd1) || op_q;
    assign last_word    = cur.descending ? (word_q == '0) : (word_q == LAST_WORD);

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        op_d    = op_q;
        word_d  = word_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_accept) begin
                    state_d = RUN;
                    elem_d  = '0;
                    op_d    = 1'b0;
                    word_d  = '0;
                end
            end
            RUN: begin
                if (!last_op) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (!last_word) begin
                        word_d = cur.descending ? (word_q - 1'b1) : (word_q + 1'b1);
                    end else if (elem_q == LAST_ELEM) begin
                        state_d = DRAIN;
                    end else begin
                        // Load the start address of the next element directly, so the
                        // descending counter never steps below zero.
                        elem_d = elem_q + 3'd1;
                        word_d = MARCH_TABLE[elem_q + 3'd1].descending ? LAST_WORD : '0;
                    end
                end
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
            elem_q  <= '0;
            op_q    <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            op_q    <= op_d;
            word_q  <= word_d;
        end
    end

    assign u_bus.en       = run;
    assign u_bus.we       = run && cur_wr;
    assign u_bus.addr     = run ? (ADDR_WIDTH'(word_q) << BYTE_SHIFT) : '0;
    assign u_bus.wdata    = (run && cur_wr) ? (cur_inv ? ~PATTERN : PATTERN) : '0;
    assign u_bus.be       = {BE_W{run}};
    assign u_bus.exp_data = cur_inv ? ~PATTERN : PATTERN;
    assign u_bus.rdata    = ram_rdata_i;

    sp_ram_bist_chk #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_chk (
        .clk         (clk),
        .rst_i       (rst_i),
        .clr_i       (start_accept),
        .bus         (u_bus),
        .err_cnt_o   (err_cnt),
        .fail_addr_o (fail_addr_o),
        .fail_data_o (fail_data_o)
    );

    assign ram_en_o    = u_bus.en;
    assign ram_we_o    = u_bus.we;
    assign ram_addr_o  = u_bus.addr;
    assign ram_wdata_o = u_bus.wdata;
    assign ram_be_o    = u_bus.be;

    assign busy_o    = run || (state_q == DRAIN);
    assign done_o    = (state_q == DONE);
    assign pass_o    = done_o && (err_cnt == '0);
    assign err_cnt_o = err_cnt;

endmodule

// File: tb/tb_sp_ram_bist.sv
// Self-checking bench: behavioural faulty RAM, March C- request/result model
// built from the algorithm description, plus a checker saturation run.
module tb_sp_ram_bist;

    localparam int          RAM_SIZE = 64;
    localparam int          AW       = 6;
    localparam int          DW       = 32;
    localparam int          N        = 16;
    localparam logic [31:0] PAT      = 32'h5555_5555;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i, start_i;
    logic          busy, done, pass;
    logic [15:0]   err_cnt;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [3:0]    ram_be;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] s0 [N];
    logic [DW-1:0] s1 [N];
    logic [DW-1:0] ram [N];
    logic [43:0]   exp_req [$];

    // March C- as the textbook lists it: 0=r0 1=r1 2=w0 3=w1 -1=none.
    int m_desc [6] = '{0, 0, 0, 1, 1, 0};
    int m_op0  [6] = '{2, 0, 1, 0, 1, 0};
    int m_op1  [6] = '{-1, 3, 2, 3, 2, -1};

    sp_ram_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_bus ();

    assign ram_bus.en       = ram_en;
    assign ram_bus.we       = ram_we;
    assign ram_bus.addr     = ram_addr;
    assign ram_bus.wdata    = ram_wdata;
    assign ram_bus.be       = ram_be;
    assign ram_bus.exp_data = '0;
    assign ram_rdata        = ram_bus.rdata;

    sp_ram_bist #(
        .RAM_SIZE   (RAM_SIZE),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .PATTERN    (PAT)
    ) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .busy_o      (busy),
        .done_o      (done),
        .pass_o      (pass),
        .err_cnt_o   (err_cnt),
        .fail_addr_o (fail_addr),
        .fail_data_o (fail_data),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_be_o    (ram_be),
        .ram_rdata_i (ram_rdata)
    );

    sp_ram_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) chk_bus ();
    logic          chk_rst, chk_clr;
    logic [15:0]   u_err;
    logic [AW-1:0] u_fa;
    logic [DW-1:0] u_fd;

    sp_ram_bist_chk #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_chk (
        .clk         (clk),
        .rst_i       (chk_rst),
        .clr_i       (chk_clr),
        .bus         (chk_bus),
        .err_cnt_o   (u_err),
        .fail_addr_o (u_fa),
        .fail_data_o (u_fd)
    );

    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a);
        return (v | s1[a]) & ~s0[a];
    endfunction

    function automatic logic [DW-1:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    always @(posedge clk) begin
        if (ram_bus.en && ram_bus.we)
            ram[ram_bus.addr[AW-1:2]] <= (ram[ram_bus.addr[AW-1:2]] & ~be_mask(ram_bus.be))
                                       | (ram_bus.wdata & be_mask(ram_bus.be));
        if (ram_bus.en && !ram_bus.we)
            ram_bus.rdata <= faulty(ram[ram_bus.addr[AW-1:2]], int'(ram_bus.addr[AW-1:2]));
    end

    function automatic logic [100:0] outs();
        return {busy, done, pass, err_cnt, fail_addr, fail_data,
                ram_en, ram_we, ram_addr, ram_wdata, ram_be};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            s0[i] = '0;
            s1[i] = '0;
        end
    endtask

    task automatic build_model(output int e_err, output logic [AW-1:0] e_fa, output logic [DW-1:0] e_fd);
        logic [DW-1:0] mm [N];
        logic [DW-1:0] bg, v;
        int a, code;
        exp_req.delete();
        e_err = 0;
        e_fa  = '0;
        e_fd  = '0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                a = (m_desc[e] != 0) ? (N - 1 - k) : k;
                for (int o = 0; o < 2; o++) begin
                    code = (o == 0) ? m_op0[e] : m_op1[e];
                    if (code < 0) continue;
                    bg = (code % 2 == 1) ? ~PAT : PAT;
                    if (code >= 2) begin
                        exp_req.push_back({1'b1, 1'b1, AW'(a * 4), bg, 4'hF});
                        mm[a] = bg;
                    end else begin
                        exp_req.push_back({1'b1, 1'b0, AW'(a * 4), 32'h0, 4'hF});
                        v = faulty(mm[a], a);
                        if (v != bg) begin
                            if (e_err == 0) begin
                                e_fa = AW'(a * 4);
                                e_fd = v;
                            end
                            e_err++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_test(input string name, input bit hold, input int abort_at);
        int            e_err;
        logic [AW-1:0] e_fa;
        logic [DW-1:0] e_fd;
        int            busy_cycles;
        build_model(e_err, e_fa, e_fd);
        busy_cycles = 0;
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1;
        if (!hold) start_i = 1'b0;
        check({name, ":start_clear"}, {done, pass, err_cnt, fail_addr, fail_data}, '0);
        for (int i = 0; i < 10 * N; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            busy_cycles += int'(busy);
            check($sformatf("%s:req%0d", name, i), {ram_en, ram_we, ram_addr, ram_wdata, ram_be}, exp_req[i]);
            if (i == 0) check({name, ":m0_wdata_be"}, {ram_wdata, ram_be}, {PAT, 4'hF});
            if (i == 5 * N) check({name, ":m3_first_addr"}, {ram_we, ram_addr}, {1'b0, 6'h3C});
            if (i == abort_at) begin
                rst_i = 1'b1;
                @(posedge clk); #1;
                rst_i = 1'b0;
                check({name, ":abort_outputs"}, outs(), '0);
                @(posedge clk); #1;
                check({name, ":abort_discard"}, outs(), '0);
                return;
            end
        end
        @(posedge clk); #1;
        busy_cycles += int'(busy);
        check({name, ":drain"}, {busy, done, ram_en}, 3'b100);
        @(posedge clk); #1;
        start_i = 1'b0;
        check({name, ":busy_len"}, {busy, 32'(busy_cycles)}, {1'b0, 32'd161});
        check({name, ":result"}, {done, pass, err_cnt, fail_addr, fail_data},
              {1'b1, (e_err == 0), 16'(e_err), e_fa, e_fd});
    endtask

    initial begin
        int w, b, nf;
        rst_i   = 1'b1;
        start_i = 1'b0;
        chk_rst = 1'b1;
        chk_clr = 1'b0;
        chk_bus.en = 1'b0;  chk_bus.we = 1'b0;  chk_bus.addr = '0;
        chk_bus.wdata = '0; chk_bus.be = '0;    chk_bus.exp_data = '0;
        chk_bus.rdata = '0;
        clear_faults();

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", outs(), '0);
        rst_i   = 1'b0;
        chk_rst = 1'b0;
        @(posedge clk); #1;
        check("idle_state", outs(), '0);

        run_test("clean", 1'b0, -1);

        s1[5] = 32'h0000_0008;
        run_test("w5b3_sa1", 1'b0, -1);
        check("w5b3_values", {done, pass, err_cnt, fail_addr, fail_data},
              {1'b1, 1'b0, 16'd3, 6'h14, 32'h5555_555D});

        clear_faults();
        run_test("hold_start", 1'b1, -1);

        s0[0]  = '1;
        s0[12] = '1;
        run_test("abort", 1'b0, 40);
        clear_faults();
        run_test("post_abort", 1'b0, -1);

        s0[0] = '1;
        run_test("w0_sa0", 1'b0, -1);

        for (int r = 0; r < 4; r++) begin
            clear_faults();
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                w = $urandom_range(0, N - 1);
                b = $urandom_range(0, DW - 1);
                if ($urandom_range(0, 1) == 1) s1[w] |= (32'h1 << b);
                else                           s0[w] |= (32'h1 << b);
            end
            run_test($sformatf("rand%0d", r), 1'b0, -1);
        end
        clear_faults();

        // Checker on its own: first-fail capture, clear, then a long error loop.
        @(posedge clk); #1 chk_clr = 1'b1;
        @(posedge clk); #1 chk_clr = 1'b0;
        chk_bus.en = 1'b1; chk_bus.we = 1'b0; chk_bus.addr = 6'h14; chk_bus.exp_data = PAT;
        @(posedge clk); #1;
        chk_bus.rdata = 32'h5555_555D;
        chk_bus.addr  = 6'h18;
        @(posedge clk); #1;
        chk_bus.en    = 1'b0;
        chk_bus.rdata = 32'h0;
        @(posedge clk); #1;
        check("chk_first_fail", {u_err, u_fa, u_fd}, {16'd2, 6'h14, 32'h5555_555D});
        chk_clr = 1'b1;
        @(posedge clk); #1 chk_clr = 1'b0;
        check("chk_clear", {u_err, u_fa, u_fd}, '0);

        chk_bus.en = 1'b1; chk_bus.we = 1'b0; chk_bus.addr = 6'h00;
        chk_bus.exp_data = PAT; chk_bus.rdata = 32'h0;
        for (int k = 1; k <= 65540; k++) begin
            @(posedge clk); #1;
            if (k == 2 || k == 65535 || k == 65536 || k == 65537 || k == 65540)
                check($sformatf("chk_sat_k%0d", k), u_err, (k - 1 > 65535) ? 16'hFFFF : 16'(k - 1));
        end
        chk_bus.en = 1'b0;
        check("chk_sat_first", {u_fa, u_fd}, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
